// File: rtl/unidade_controle_seq_pkg.sv
// Shared opcodes, ALU operation codes and time-step state encoding for the sequencing control unit.
package unidade_controle_seq_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  // Codes are visible on Tstep, so the encoding is fixed.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4
  } state_t;

endpackage

// File: rtl/unidade_controle_seq_decoder_onehot.sv
// Binary to one-hot decoder; all-zero when disabled or when the index is out of range.
module decoder_onehot #(
  parameter int W_IN  = 3,
  parameter int N_OUT = 8
) (
  input  logic [W_IN-1:0]  W,
  input  logic             En,
  output logic [N_OUT-1:0] Y
);

  always_comb begin
    Y = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (En && (int'(W) == i)) Y[i] = 1'b1;
    end
  end

endmodule

// File: rtl/unidade_controle_seq.sv
// Control unit with its own T0..T3 step FSM; decodes mv, mvi, add, sub for NREG registers.
// Define ALU_AND_EN to also decode opcode 100 as and; otherwise opcode 100 is illegal.
module unidade_controle_seq
  import unidade_controle_seq_pkg::*;
#(
  parameter int NREG   = 8,
  parameter int RSEL_W = 3,
  parameter int OPC_W  = 3,
  parameter int IW     = OPC_W + 2*RSEL_W
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [IW-1:0]   Instrucao,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic            DINout,
  output logic [1:0]      AluOp,
  output logic            Done,
  output logic            Busy,
  output logic            Illegal,
  output logic [2:0]      Tstep
);

  state_t state;

  logic [OPC_W-1:0]  opcode;
  logic [RSEL_W-1:0] rx, ry;
  logic              is_mv, is_mvi, is_alu, regs_ok, legal;
  logic [1:0]        alu_code;
  logic [NREG-1:0]   rx_oh, ry_oh;

  assign opcode = Instrucao[IW-1 -: OPC_W];
  assign rx     = Instrucao[2*RSEL_W-1 -: RSEL_W];
  assign ry     = Instrucao[RSEL_W-1:0];

  always_comb begin
    is_alu   = 1'b0;
    alu_code = ALU_ADD;
    case (opcode)
      OPC_W'(OP_ADD): begin is_alu = 1'b1; alu_code = ALU_ADD; end
      OPC_W'(OP_SUB): begin is_alu = 1'b1; alu_code = ALU_SUB; end
`ifdef ALU_AND_EN
      OPC_W'(OP_AND): begin is_alu = 1'b1; alu_code = ALU_AND; end
`endif
      default: ;
    endcase
  end

  assign is_mv   = (opcode == OPC_W'(OP_MV));
  assign is_mvi  = (opcode == OPC_W'(OP_MVI));
  assign regs_ok = (int'(rx) < NREG) && (int'(ry) < NREG);
  assign legal   = regs_ok && (is_mv || is_mvi || is_alu);

  decoder_onehot #(.W_IN(RSEL_W), .N_OUT(NREG)) u_dec_rx (.W(rx), .En(legal), .Y(rx_oh));
  decoder_onehot #(.W_IN(RSEL_W), .N_OUT(NREG)) u_dec_ry (.W(ry), .En(legal), .Y(ry_oh));

  always_comb begin
    IRin    = 1'b0;
    Rin     = '0;
    Rout    = '0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    DINout  = 1'b0;
    AluOp   = ALU_ADD;
    Done    = 1'b0;
    Illegal = 1'b0;
    case (state)
      S_T0: IRin = 1'b1;
      S_T1: begin
        if (!legal) begin
          Illegal = 1'b1;
          Done    = 1'b1;
        end else if (is_mv) begin
          Rout = ry_oh;
          Rin  = rx_oh;
          Done = 1'b1;
        end else if (is_mvi) begin
          DINout = 1'b1;
          Rin    = rx_oh;
          Done   = 1'b1;
        end else begin
          Rout = rx_oh;
          Ain  = 1'b1;
        end
      end
      S_T2: begin
        Rout  = ry_oh;
        Gin   = 1'b1;
        AluOp = alu_code;
      end
      S_T3: begin
        Gout = 1'b1;
        Rin  = rx_oh;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  assign Busy  = (state != S_IDLE);
  assign Tstep = state;

  // A Done cycle doubles as an IDLE decision point so back-to-back instructions skip IDLE.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (Run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   state <= Done ? (Run ? S_T0 : S_IDLE) : S_T2;
        S_T2:   state <= S_T3;
        S_T3:   state <= Run ? S_T0 : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle_seq.sv
// Bench: two instances (NREG=8 and NREG=6) against an instruction-length reference model.
module tb_unidade_controle_seq;

`ifdef ALU_AND_EN
  localparam bit AND_EN = 1'b1;
`else
  localparam bit AND_EN = 1'b0;
`endif

  typedef struct packed {
    logic        irin;
    logic [15:0] rin;
    logic [15:0] rout;
    logic        ain;
    logic        gin;
    logic        gout;
    logic        dinout;
    logic [1:0]  aluop;
    logic        done;
    logic        busy;
    logic        illegal;
    logic [2:0]  tstep;
  } out_t;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Run, Run6;
  logic [8:0] Instrucao, Instr6;

  logic       IRin, Ain, Gin, Gout, DINout, Done, Busy, Illegal;
  logic [7:0] Rin, Rout;
  logic [1:0] AluOp;
  logic [2:0] Tstep;
  logic       IRin6, Ain6, Gin6, Gout6, DINout6, Done6, Busy6, Illegal6;
  logic [5:0] Rin6, Rout6;
  logic [1:0] AluOp6;
  logic [2:0] Tstep6;

  out_t act8, act6;
  int   checks = 0;
  int   errors = 0;
  int   ph8 = 0;
  int   ph6 = 0;
  int   busy_cnt;
  logic [8:0] ri8, ri6;
  logic       rr8, rr6;

  always #5 Clock = ~Clock;

  unidade_controle_seq dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Instrucao(Instrucao),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .DINout(DINout), .AluOp(AluOp), .Done(Done), .Busy(Busy), .Illegal(Illegal), .Tstep(Tstep)
  );

  unidade_controle_seq #(.NREG(6)) dut6 (
    .Clock(Clock), .Resetn(Resetn), .Run(Run6), .Instrucao(Instr6),
    .IRin(IRin6), .Rin(Rin6), .Rout(Rout6), .Ain(Ain6), .Gin(Gin6), .Gout(Gout6),
    .DINout(DINout6), .AluOp(AluOp6), .Done(Done6), .Busy(Busy6), .Illegal(Illegal6), .Tstep(Tstep6)
  );

  assign act8 = {IRin, 8'b0, Rin, 8'b0, Rout, Ain, Gin, Gout, DINout, AluOp, Done, Busy, Illegal, Tstep};
  assign act6 = {IRin6, 10'b0, Rin6, 10'b0, Rout6, Ain6, Gin6, Gout6, DINout6, AluOp6, Done6, Busy6, Illegal6, Tstep6};

  function automatic bit is_legal(logic [8:0] ins, int nreg);
    int op, rx, ry;
    op = int'(ins[8:6]);
    rx = int'(ins[5:3]);
    ry = int'(ins[2:0]);
    return (op <= 3 || (op == 4 && AND_EN)) && rx < nreg && ry < nreg;
  endfunction

  // Cycles an instruction occupies from its fetch step onward.
  function automatic int ilen(logic [8:0] ins, int nreg);
    return (is_legal(ins, nreg) && int'(ins[8:6]) >= 2) ? 4 : 2;
  endfunction

  function automatic int nxt(int ph, logic run, logic [8:0] ins, int nreg);
    if (ph != 0 && ph < ilen(ins, nreg)) return ph + 1;
    return run ? 1 : 0;
  endfunction

  function automatic out_t expect_out(int ph, logic [8:0] ins, int nreg);
    out_t o;
    int op, rx, ry;
    o  = '0;
    op = int'(ins[8:6]);
    rx = int'(ins[5:3]);
    ry = int'(ins[2:0]);
    o.busy  = (ph != 0);
    o.tstep = 3'(ph);
    case (ph)
      1: o.irin = 1'b1;
      2: begin
        if (!is_legal(ins, nreg)) begin
          o.illegal = 1'b1; o.done = 1'b1;
        end else if (op == 0) begin
          o.rout = 16'(1) << ry; o.rin = 16'(1) << rx; o.done = 1'b1;
        end else if (op == 1) begin
          o.dinout = 1'b1; o.rin = 16'(1) << rx; o.done = 1'b1;
        end else begin
          o.rout = 16'(1) << rx; o.ain = 1'b1;
        end
      end
      3: begin o.rout = 16'(1) << ry; o.gin = 1'b1; o.aluop = 2'(op - 2); end
      4: begin o.gout = 1'b1; o.rin = 16'(1) << rx; o.done = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input logic [44:0] act, input logic [44:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic r8, input logic [8:0] i8, input logic r6, input logic [8:0] i6);
    @(negedge Clock);
    Run = r8; Instrucao = i8; Run6 = r6; Instr6 = i6;
    #1;
    chk("model8", act8, expect_out(ph8, Instrucao, 8));
    chk("model6", act6, expect_out(ph6, Instr6, 6));
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    ph8 = nxt(ph8, Run, Instrucao, 8);
    ph6 = nxt(ph6, Run6, Instr6, 6);
  endtask

  localparam logic [8:0] MV35  = 9'b000_011_101;
  localparam logic [8:0] MVI7  = 9'b001_111_000;
  localparam logic [8:0] SUB12 = 9'b011_001_010;
  localparam logic [8:0] ADD12 = 9'b010_001_010;
  localparam logic [8:0] AND12 = 9'b100_001_010;
  localparam logic [8:0] MV60  = 9'b000_110_000;

  initial begin
    Resetn = 1'b0; Run = 1'b0; Run6 = 1'b0; Instrucao = '0; Instr6 = '0;
    #3;
    chk("reset8", act8, '0);
    chk("reset6", act6, '0);
    #4 Resetn = 1'b1;

    // mv R3,R5
    drive(1, MV35, 0, 0); tick();
    drive(0, MV35, 0, 0); chk("mv_t0_irin", IRin, 1); tick();
    drive(0, MV35, 0, 0);
    chk("mv_t1_rout", Rout, 8'b0010_0000);
    chk("mv_t1_rin", Rin, 8'b0000_1000);
    chk("mv_t1_done", Done, 1);
    tick();
    drive(0, MV35, 0, 0); chk("mv_idle", Tstep, 0); tick();

    // mvi R7
    drive(1, MVI7, 0, 0); tick();
    drive(0, MVI7, 0, 0); tick();
    drive(0, MVI7, 0, 0);
    chk("mvi_dinout", DINout, 1);
    chk("mvi_rin", Rin, 8'b1000_0000);
    tick();

    // sub R1,R2
    drive(1, SUB12, 0, 0); tick();
    drive(0, SUB12, 0, 0); tick();
    drive(0, SUB12, 0, 0); chk("sub_t1_rout", Rout, 8'b0000_0010); chk("sub_t1_ain", Ain, 1); tick();
    drive(0, SUB12, 0, 0); chk("sub_t2_rout", Rout, 8'b0000_0100); chk("sub_t2_aluop", AluOp, 2'b01); tick();
    drive(0, SUB12, 0, 0); chk("sub_t3_rin", Rin, 8'b0000_0010); chk("sub_t3_gout", Gout, 1); tick();

    // two adds back to back with Run held
    drive(1, ADD12, 0, 0); tick();
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(i != 7, ADD12, 0, 0);
      if (Busy) busy_cnt++;
      if (i == 4) chk("b2b_t0", Tstep, 3'd1);
      tick();
    end
    drive(0, ADD12, 0, 0);
    chk("b2b_idle", Tstep, 0);
    chk("b2b_cycles", 45'(busy_cnt), 8);
    tick();

    // asynchronous reset during T2 of an add
    drive(1, ADD12, 0, 0); tick();
    drive(0, ADD12, 0, 0); tick();
    drive(0, ADD12, 0, 0); tick();
    drive(0, ADD12, 0, 0); chk("add_t2_gin", Gin, 1);
    #1 Resetn = 1'b0;
    #1;
    chk("arst_tstep", Tstep, 0);
    chk("arst_gin", Gin, 0);
    ph8 = 0; ph6 = 0;
    @(posedge Clock);
    #2 Resetn = 1'b1;

    // NREG=6: R6 out of range
    drive(0, 0, 1, MV60); tick();
    drive(0, 0, 0, MV60); tick();
    drive(0, 0, 0, MV60);
    chk("n6_illegal", Illegal6, 1);
    chk("n6_done", Done6, 1);
    chk("n6_rin", Rin6, 0);
    tick();

    // opcode 100
    busy_cnt = 0;
    drive(1, AND12, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, AND12, 0, 0);
      if (Busy) busy_cnt++;
      if (i == 1) chk("and_illegal", Illegal, AND_EN ? 45'd0 : 45'd1);
      tick();
    end
    chk("and_cycles", 45'(busy_cnt), AND_EN ? 45'd4 : 45'd2);

    // random traffic; instructions only change while fetching or idle
    ri8 = '0; ri6 = '0;
    for (int c = 0; c < 600; c++) begin
      if (ph8 <= 1 && $urandom_range(0, 1) == 1) ri8 = 9'($urandom_range(0, 511));
      if (ph6 <= 1 && $urandom_range(0, 1) == 1) ri6 = 9'($urandom_range(0, 511));
      rr8 = 1'($urandom_range(0, 1));
      rr6 = 1'($urandom_range(0, 1));
      drive(rr8, ri8, rr6, ri6);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
